// File: rtl/axi_bsq_pkg.sv
// rtl/axi_bsq_pkg.sv - shared constants and types for the BRAM stack/queue controller
package axi_bsq_pkg;

    // Register word indices (byte offset >> 2)
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_THRESH = 3'd3;
    localparam logic [2:0] REG_PEEK   = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic MODE_LIFO = 1'b0;
    localparam logic MODE_FIFO = 1'b1;

    localparam int ST_EMPTY     = 16;
    localparam int ST_FULL      = 17;
    localparam int ST_OVERFLOW  = 18;
    localparam int ST_UNDERFLOW = 19;

    localparam int CTRL_MODE   = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;
    localparam int CTRL_W1C    = 3;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_MEM  = 2'd1,
        RD_RESP = 2'd2
    } rd_state_t;

endpackage

// File: rtl/bsq_bram.sv
// rtl/bsq_bram.sv - single-port RAM with registered read for block-RAM inference
module bsq_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // dout only moves on a read enable so it holds through the response phase
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        if (en) dout <= mem[addr];
    end

endmodule

// File: rtl/axi_bram_stack_queue_ctrl.sv
// rtl/axi_bram_stack_queue_ctrl.sv - AXI4-Lite LIFO/FIFO buffer over a single-port BRAM
module axi_bram_stack_queue_ctrl
    import axi_bsq_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int DEPTH              = 1024,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          irq
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    rd_state_t             state, state_nxt;
    logic [ADDR_W:0]       count, thresh;
    logic [ADDR_W-1:0]     wr_ptr, rd_ptr, pop_addr, ram_addr;
    logic                  mode, irq_en, ovf, udf;
    logic [2:0]            rd_sel, aw_sel;
    logic                  rd_err, bvalid, empty, full, wr_fire, push_ok, rd_is_mem;
    logic [1:0]            bresp;
    logic [31:0]           reg_rdata, reg_mux, status_word;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  unused_bits;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign aw_sel    = S_AXI_AWADDR[4:2];
    assign rd_is_mem = (rd_sel == REG_DATA) || (rd_sel == REG_PEEK);
    // Writes are held off during RD_MEM so the single RAM port never sees both
    assign wr_fire   = ARESETN && S_AXI_AWVALID && S_AXI_WVALID && !bvalid && (state != RD_MEM);
    assign push_ok   = wr_fire && (aw_sel == REG_DATA) && !full;
    assign pop_addr  = (mode == MODE_FIFO) ? rd_ptr : ADDR_W'(count - 1'b1);
    assign ram_addr  = (state == RD_MEM) ? pop_addr
                     : ((mode == MODE_FIFO) ? wr_ptr : count[ADDR_W-1:0]);

    assign S_AXI_AWREADY = wr_fire;
    assign S_AXI_WREADY  = wr_fire;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = (state == RD_RESP);
    assign S_AXI_RRESP   = (state == RD_RESP && rd_err) ? RESP_SLVERR : RESP_OKAY;
    assign irq           = irq_en && (count >= thresh);
    assign unused_bits   = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WSTRB, S_AXI_WDATA};

    bsq_bram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bram (
        .clk  (ACLK),
        .we   (push_ok),
        .en   (state == RD_MEM && rd_is_mem && !empty),
        .addr (ram_addr),
        .din  (S_AXI_WDATA[DATA_WIDTH-1:0]),
        .dout (ram_dout)
    );

    always_comb begin
        state_nxt     = state;
        S_AXI_ARREADY = 1'b0;
        unique case (state)
            RD_IDLE: if (ARESETN && S_AXI_ARVALID && !wr_fire) begin
                S_AXI_ARREADY = 1'b1;
                state_nxt     = RD_MEM;
            end
            RD_MEM:  state_nxt = RD_RESP;
            RD_RESP: if (S_AXI_RREADY) state_nxt = RD_IDLE;
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        status_word               = '0;
        status_word[ADDR_W:0]     = count;
        status_word[ST_EMPTY]     = empty;
        status_word[ST_FULL]      = full;
        status_word[ST_OVERFLOW]  = ovf;
        status_word[ST_UNDERFLOW] = udf;
        reg_mux = '0;
        case (rd_sel)
            REG_STATUS: reg_mux = status_word;
            REG_CTRL: begin
                reg_mux[CTRL_MODE]   = mode;
                reg_mux[CTRL_IRQ_EN] = irq_en;
            end
            REG_THRESH: reg_mux[ADDR_W:0] = thresh;
            default: ;
        endcase
    end

    always_comb begin
        S_AXI_RDATA = '0;
        if (state == RD_RESP) begin
            if (!rd_is_mem)  S_AXI_RDATA = reg_rdata;
            else if (!rd_err) S_AXI_RDATA[DATA_WIDTH-1:0] = ram_dout;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state     <= RD_IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mode      <= MODE_LIFO;
            irq_en    <= 1'b0;
            thresh    <= DEPTH_C;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            rd_sel    <= REG_DATA;
            rd_err    <= 1'b0;
            reg_rdata <= '0;
            bresp     <= RESP_OKAY;
            bvalid    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
            if (S_AXI_ARREADY) rd_sel <= S_AXI_ARADDR[4:2];
            if (wr_fire) begin
                bvalid <= 1'b1;
                bresp  <= RESP_OKAY;
                case (aw_sel)
                    REG_DATA: begin
                        if (full) begin
                            ovf   <= 1'b1;
                            bresp <= RESP_SLVERR;
                        end else begin
                            count <= count + 1'b1;
                            if (mode == MODE_FIFO) wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                    REG_CTRL: if (S_AXI_WSTRB[0]) begin
                        if (empty) mode <= S_AXI_WDATA[CTRL_MODE];
                        irq_en <= S_AXI_WDATA[CTRL_IRQ_EN];
                        if (S_AXI_WDATA[CTRL_W1C]) begin
                            ovf <= 1'b0;
                            udf <= 1'b0;
                        end
                        if (S_AXI_WDATA[CTRL_CLEAR]) begin
                            count  <= '0;
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                            ovf    <= 1'b0;
                            udf    <= 1'b0;
                        end
                    end
                    REG_THRESH: thresh <= S_AXI_WDATA[ADDR_W:0];
                    default: ;
                endcase
            end
            // Pop bookkeeping; peeks and register reads only capture data here
            if (state == RD_MEM) begin
                rd_err    <= rd_is_mem && empty;
                reg_rdata <= reg_mux;
                if (rd_sel == REG_DATA) begin
                    if (empty) begin
                        udf <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                        if (mode == MODE_FIFO) rd_ptr <= rd_ptr + 1'b1;
                    end
                end
            end
        end
    end

endmodule
